// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-lane TDM receive demux with slot-0 marker alignment
// Rebuilds four lanes from a slot-serial stream and reports alignment errors.
module tdm_demux4 #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [1:0]       slot, slot_d;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] out0_d, out1_d, out2_d, out3_d;
  logic             fv_d, se_d;
  logic [ERR_W-1:0] err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      sh0         <= sh0_d;
      sh1         <= sh1_d;
      sh2         <= sh2_d;
      out0        <= out0_d;
      out1        <= out1_d;
      out2        <= out2_d;
      out3        <= out3_d;
      frame_valid <= fv_d;
      sync_err    <= se_d;
      err_count   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    slot_d  = slot;
    sh0_d   = sh0;
    sh1_d   = sh1;
    sh2_d   = sh2;
    out0_d  = out0;
    out1_d  = out1;
    out2_d  = out2;
    out3_d  = out3;
    fv_d    = 1'b0;
    se_d    = 1'b0;

    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A marker mid-frame restarts the frame on this beat.
            se_d   = (slot != 2'd0);
            sh0_d  = din;
            slot_d = 2'd1;
          end else if (slot == 2'd0) begin
            se_d    = 1'b1;
            state_d = HUNT;
            slot_d  = 2'd0;
          end else if (slot == 2'd3) begin
            out0_d = sh0;
            out1_d = sh1;
            out2_d = sh2;
            out3_d = din;
            fv_d   = 1'b1;
            slot_d = 2'd0;
          end else begin
            if (slot == 2'd1) sh1_d = din;
            else              sh2_d = din;
            slot_d = slot + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_d = (se_d && err_count != ERR_MAX) ? err_count + ERR_ONE : err_count;
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed and randomized checks of tdm_demux4 against a frame-queue model
module tb_tdm_demux4;

  localparam int W = 4;
  localparam int EW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic [W-1:0]  out0, out1, out2, out3;
  logic          frame_valid, locked, sync_err;
  logic [EW-1:0] err_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: beats of the current frame collected in a queue.
  logic [W-1:0]  mq[$];
  logic [W-1:0]  m_out[4];
  logic          m_lock, m_fv, m_se;
  int            m_err;

  tdm_demux4 #(.WIDTH(W), .ERR_W(EW)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic model_step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_lock = 1'b0;
      mq.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_err = 0;
    end else if (v) begin
      if (!m_lock) begin
        if (fs) begin
          mq.delete();
          mq.push_back(d);
          m_lock = 1'b1;
        end
      end else if (fs) begin
        if (mq.size() != 0) m_se = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() == 0) begin
        m_se = 1'b1;
        m_lock = 1'b0;
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = mq[i];
          m_fv = 1'b1;
          mq.delete();
        end
      end
      if (m_se && m_err < (1 << EW) - 1) m_err++;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
    reset = r;
    din_valid = v;
    frame_sync = fs;
    din = d;
    @(posedge clock);
    model_step(r, v, fs, d);
    @(negedge clock);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 4'hF);
    n_cmp++;
    if ({out0, out1, out2, out3, frame_valid, locked, sync_err, err_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state got %h exp 0", {out0, out1, out2, out3, frame_valid, locked, sync_err, err_count});
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_basic;
    cycle(0, 1, 1, 4'h1);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL basic_locked got %b exp 1", locked);
    end
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 0, 4'h1);
    cycle(0, 1, 0, 4'h0);
    n_cmp++;
    if ({out0, out1, out2, out3, frame_valid} !== {4'h1, 4'h0, 4'h1, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL basic_frame got %h %h %h %h fv=%b exp 1 0 1 0 fv=1", out0, out1, out2, out3, frame_valid);
    end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_fv_pulse got %b exp 0", frame_valid);
    end
  endtask

  task automatic test_gaps;
    logic [W-1:0] vals[4];
    int fv_seen, se_seen;
    vals = '{4'h1, 4'h0, 4'h1, 4'h0};
    fv_seen = 0;
    se_seen = 0;
    cycle(1, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      cycle(0, 1, (b == 0), vals[b]);
      fv_seen += frame_valid;
      se_seen += sync_err;
      for (int g = 0; g < 2; g++) begin
        cycle(0, 0, 1, 4'hF);
        fv_seen += frame_valid;
        se_seen += sync_err;
      end
    end
    n_cmp++;
    if ({out0, out1, out2, out3} !== {4'h1, 4'h0, 4'h1, 4'h0}) begin
      n_err++;
      $display("FAIL gaps_frame got %h %h %h %h exp 1 0 1 0", out0, out1, out2, out3);
    end
    n_cmp++;
    if (fv_seen !== 1 || se_seen !== 0) begin
      n_err++;
      $display("FAIL gaps_pulses got fv=%0d se=%0d exp fv=1 se=0", fv_seen, se_seen);
    end
  endtask

  task automatic test_hunt;
    cycle(1, 0, 0, 0);
    for (int b = 0; b < 3; b++) cycle(0, 1, 0, 4'h5);
    n_cmp++;
    if ({locked, err_count, out0, out1, out2, out3} !== '0) begin
      n_err++;
      $display("FAIL hunt_idle got locked=%b err=%0d outs=%h%h%h%h exp all 0", locked, err_count, out0, out1, out2, out3);
    end
    cycle(0, 1, 1, 4'h0);
    cycle(0, 1, 0, 4'h1);
    cycle(0, 1, 0, 4'h1);
    cycle(0, 1, 0, 4'h0);
    n_cmp++;
    if ({out0, out1, out2, out3, frame_valid} !== {4'h0, 4'h1, 4'h1, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL hunt_frame got %h %h %h %h fv=%b exp 0 1 1 0 fv=1", out0, out1, out2, out3, frame_valid);
    end
  endtask

  task automatic test_early_marker;
    cycle(0, 1, 1, 4'h1);
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 1, 4'h1);
    n_cmp++;
    if ({sync_err, err_count, frame_valid, out0, out1, out2, out3} !== {1'b1, 2'd1, 1'b0, 4'h0, 4'h1, 4'h1, 4'h0}) begin
      n_err++;
      $display("FAIL early_err got se=%b err=%0d fv=%b outs=%h%h%h%h exp se=1 err=1 fv=0 outs=0110",
               sync_err, err_count, frame_valid, out0, out1, out2, out3);
    end
    for (int b = 0; b < 3; b++) cycle(0, 1, 0, 4'h1);
    n_cmp++;
    if ({out0, out1, out2, out3, frame_valid, sync_err} !== {4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL early_refill got %h %h %h %h fv=%b se=%b exp 1 1 1 1 fv=1 se=0", out0, out1, out2, out3, frame_valid, sync_err);
    end
  endtask

  task automatic test_missing_marker;
    cycle(0, 1, 0, 4'h7);
    n_cmp++;
    if ({sync_err, locked, err_count} !== {1'b1, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL missing_err got se=%b locked=%b err=%0d exp se=1 locked=0 err=2", sync_err, locked, err_count);
    end
    cycle(0, 1, 1, 4'h0);
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 0, 4'h1);
    n_cmp++;
    if ({locked, out0, out1, out2, out3, frame_valid} !== {1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1}) begin
      n_err++;
      $display("FAIL missing_relock got locked=%b outs=%h%h%h%h fv=%b exp locked=1 outs=0001 fv=1",
               locked, out0, out1, out2, out3, frame_valid);
    end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 4'h3);
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 1, 1, 4'($urandom_range(0, 15)));
      exp_cnt = (k < 3) ? k : 3;
      n_cmp++;
      if (err_count !== EW'(exp_cnt) || sync_err !== 1'b1) begin
        n_err++;
        $display("FAIL sat_err_%0d got err=%0d se=%b exp err=%0d se=1", k, err_count, sync_err, exp_cnt);
      end
    end
    cycle(0, 1, 0, 4'h9);
    cycle(1, 0, 0, 0);
    n_cmp++;
    if ({out0, out1, out2, out3, frame_valid, locked, sync_err, err_count} !== '0) begin
      n_err++;
      $display("FAIL sat_midreset got %h exp 0", {out0, out1, out2, out3, frame_valid, locked, sync_err, err_count});
    end
  endtask

  task automatic test_random;
    logic v, fs, r;
    logic [W-1:0] d;
    cycle(1, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      fs = ($urandom_range(0, 9) < 3);
      d = W'($urandom);
      cycle(r, v, fs, d);
      n_cmp++;
      if ({out0, out1, out2, out3} !== {m_out[0], m_out[1], m_out[2], m_out[3]} ||
          frame_valid !== m_fv || sync_err !== m_se || locked !== m_lock || err_count !== EW'(m_err)) begin
        n_err++;
        $display("FAIL rand_c%0d got outs=%h%h%h%h fv=%b se=%b lk=%b err=%0d exp outs=%h%h%h%h fv=%b se=%b lk=%b err=%0d",
                 c, out0, out1, out2, out3, frame_valid, sync_err, locked, err_count,
                 m_out[0], m_out[1], m_out[2], m_out[3], m_fv, m_se, m_lock, m_err);
      end
      n_cmp++;
      if (frame_valid && sync_err) begin
        n_err++;
        $display("FAIL rand_excl_c%0d got fv=1 se=1 exp not both", c);
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_gaps();
    test_hunt();
    test_early_marker();
    test_missing_marker();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
